mac_tx_arbiter: RTL
===================

// Module: mac_tx_arbiter
// PURPOSE
//  Frame-level arbiter sharing the single MAC TX byte interface between two frame sources
//  (src0: IQ packetizer, src1: control/ARP responder). Grants one whole frame at a time and
//  enforces an inter-frame gap. A watchdog aborts runaway frames. Sits between sources and MAC.
// PARAMETERS
//  RR_MODE     1     1 = round-robin between sources; 0 = fixed priority, src0 wins
//  GAP_CYCLES  16    idle clk cycles after each frame end before next grant (>=1)
//  MAX_BYTES   1536  accepted beats per frame before watchdog abort (11-bit count)
// PORTS
//  clk         in   1   system clock, also MAC tx_clk domain
//  rst         in   1   asynchronous, active-low reset
//  sN_req      in   1   N=0,1: source has a frame pending; held until its sop beat accepted
//  sN_data     in   8   N=0,1: frame byte
//  sN_wren     in   1   N=0,1: byte valid
//  sN_sop      in   1   N=0,1: first byte of frame
//  sN_eop      in   1   N=0,1: last byte of frame
//  sN_err      in   1   N=0,1: source-flagged error, forwarded
//  sN_rdy      out  1   N=0,1: beat accepted from source when sN_wren & sN_rdy
//  tx_data     out  8   to MAC
//  tx_wren     out  1   to MAC
//  tx_sop      out  1   to MAC
//  tx_eop      out  1   to MAC
//  tx_err      out  1   to MAC
//  tx_rdy      in   1   MAC accepts beat when tx_wren & tx_rdy
//  gnt         out  2   one-hot current grant, 00 when none
//  frames0     out  16  frames completed from src0, wraps 0xFFFF->0
//  frames1     out  16  frames completed from src1, wraps
//  aborts      out  8   watchdog aborts, saturates at 0xFF
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, gnt=00, all tx_* and sN_rdy 0, counters 0, RR pointer -> src0 next.
//  States: IDLE, ACTIVE, ABORT, FLUSH, GAP.
//  IDLE: if any req, next cycle ACTIVE with gnt set. Both req: RR_MODE=1 grants the source not
//   granted last; RR_MODE=0 grants src0. No req: stay.
//  ACTIVE: combinational passthrough, zero latency: tx_{data,wren,sop,eop,err} = granted source;
//   granted sN_rdy = tx_rdy; ungranted sN_rdy = 0. Beat accepted = tx_wren & tx_rdy.
//   Byte count clears on grant, +1 per accepted beat.
//   Accepted beat with eop: framesN +1, go GAP, gnt=00, RR pointer -> other source.
//   Count reaching MAX_BYTES with no eop accepted: go ABORT.
//   Granted sN_req may drop after sop accepted; ignored until frame ends.
//  ABORT: drive tx_wren=tx_eop=tx_err=1, tx_data=0, all sN_rdy=0; hold until tx_rdy;
//   then aborts +1 (saturating) and go FLUSH.
//  FLUSH: tx_wren=0; granted sN_rdy=1; source beats discarded until an eop beat is accepted -> GAP.
//  GAP: all tx_* 0, all sN_rdy 0; counts GAP_CYCLES cycles, then IDLE. Simultaneous new req is
//   sampled only in IDLE.
//  Outside ACTIVE/ABORT all tx_* are driven 0. tx_rdy low freezes passthrough; no beats lost.
//  Reset mid-frame: outputs drop immediately; partial frame left to MAC to discard.
// TESTING
//  src0 60-byte frame, tx_rdy=1 -> 60 beats, sop on byte0, eop on byte59, frames0=1, 16 idle cycles.
//  Both req, RR_MODE=1, 4 frames each -> grants alternate 0,1,0,1..., frames0=frames1=4.
//  Both req continuous, RR_MODE=0 -> src1 never granted, frames1=0.
//  tx_rdy low 5 cycles at byte 20 -> s0_rdy low same cycles, data byte 20 held, no loss.
//  MAX_BYTES=64, src1 sends 100 bytes -> 64 passed, err/eop beat, 36 flushed, aborts=1, frames1=0.
//  rst=0 at byte 30 -> gnt=00, tx_wren=0 same cycle; after release src0 frame starts clean.

Source files
------------

// File: rtl/mac_tx_arbiter.sv
// Frame-level arbiter sharing one MAC TX byte interface between two frame sources,
// with inter-frame gap enforcement and a watchdog that aborts runaway frames.
`timescale 1ns/1ps
module mac_tx_arbiter #(
  parameter int DATA_W     = 8,
  parameter int RR_MODE    = 1,
  parameter int GAP_CYCLES = 16,
  parameter int MAX_BYTES  = 1536
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s0_req,
  input  logic [DATA_W-1:0] s0_data,
  input  logic              s0_wren,
  input  logic              s0_sop,
  input  logic              s0_eop,
  input  logic              s0_err,
  output logic              s0_rdy,
  input  logic              s1_req,
  input  logic [DATA_W-1:0] s1_data,
  input  logic              s1_wren,
  input  logic              s1_sop,
  input  logic              s1_eop,
  input  logic              s1_err,
  output logic              s1_rdy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_wren,
  output logic              tx_sop,
  output logic              tx_eop,
  output logic              tx_err,
  input  logic              tx_rdy,
  output logic [1:0]        gnt,
  output logic [15:0]       frames0,
  output logic [15:0]       frames1,
  output logic [7:0]        aborts
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, ACTIVE, ABORT, FLUSH, GAP} state_t;

  state_t             state, state_nxt;
  logic [1:0]         gnt_nxt;
  logic               rr_ptr, rr_ptr_nxt;
  logic [10:0]        byte_cnt, byte_cnt_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic               done0, done1, abort_hit;

  logic [DATA_W-1:0]  g_data;
  logic               g_wren, g_sop, g_eop, g_err;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    g_data = s0_data;
    g_wren = s0_wren;
    g_sop  = s0_sop;
    g_eop  = s0_eop;
    g_err  = s0_err;
    if (gnt[1]) begin
      g_data = s1_data;
      g_wren = s1_wren;
      g_sop  = s1_sop;
      g_eop  = s1_eop;
      g_err  = s1_err;
    end
  end

  always_comb begin
    state_nxt    = state;
    gnt_nxt      = gnt;
    rr_ptr_nxt   = rr_ptr;
    byte_cnt_nxt = byte_cnt;
    gap_cnt_nxt  = gap_cnt;
    done0        = 1'b0;
    done1        = 1'b0;
    abort_hit    = 1'b0;
    tx_data      = '0;
    tx_wren      = 1'b0;
    tx_sop       = 1'b0;
    tx_eop       = 1'b0;
    tx_err       = 1'b0;
    s0_rdy       = 1'b0;
    s1_rdy       = 1'b0;
    case (state)
      IDLE: begin
        byte_cnt_nxt = '0;
        gap_cnt_nxt  = '0;
        if (s0_req && s1_req)
          gnt_nxt = (RR_MODE != 0 && rr_ptr) ? 2'b10 : 2'b01;
        else if (s0_req)
          gnt_nxt = 2'b01;
        else if (s1_req)
          gnt_nxt = 2'b10;
        if (s0_req || s1_req)
          state_nxt = ACTIVE;
      end
      ACTIVE: begin
        tx_data = g_data;
        tx_wren = g_wren;
        tx_sop  = g_sop;
        tx_eop  = g_eop;
        tx_err  = g_err;
        s0_rdy  = gnt[0] & tx_rdy;
        s1_rdy  = gnt[1] & tx_rdy;
        if (g_wren && tx_rdy) begin
          byte_cnt_nxt = byte_cnt + 11'd1;
          if (g_eop) begin
            done0      = gnt[0];
            done1      = gnt[1];
            gnt_nxt    = 2'b00;
            rr_ptr_nxt = gnt[0];
            state_nxt  = GAP;
          end else if (byte_cnt_nxt == 11'(MAX_BYTES)) begin
            state_nxt = ABORT;
          end
        end
      end
      ABORT: begin
        // Synthetic terminating beat tells the MAC to drop the truncated frame
        tx_wren = 1'b1;
        tx_eop  = 1'b1;
        tx_err  = 1'b1;
        if (tx_rdy) begin
          abort_hit = 1'b1;
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        s0_rdy = gnt[0];
        s1_rdy = gnt[1];
        if (g_wren && g_eop) begin
          gnt_nxt    = 2'b00;
          rr_ptr_nxt = gnt[0];
          state_nxt  = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          gap_cnt_nxt = '0;
          state_nxt   = IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gnt      <= 2'b00;
      rr_ptr   <= 1'b0;
      byte_cnt <= '0;
      gap_cnt  <= '0;
      frames0  <= '0;
      frames1  <= '0;
      aborts   <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      rr_ptr   <= rr_ptr_nxt;
      byte_cnt <= byte_cnt_nxt;
      gap_cnt  <= gap_cnt_nxt;
      if (done0)     frames0 <= frames0 + 16'd1;
      if (done1)     frames1 <= frames1 + 16'd1;
      if (abort_hit) aborts  <= sat_inc8(aborts);
    end
  end

endmodule
